// File: rtl/neosd_dat_fsm_if.sv
// neosd_dat_fsm_if: byte-stream handshake between the DAT0 engine and the data register
interface neosd_dat_fsm_if;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  modport master (output rd_data, rd_valid, wr_ready, input rd_ready, wr_data, wr_valid);
  modport slave  (input rd_data, rd_valid, wr_ready, output rd_ready, wr_data, wr_valid);
endinterface

// File: rtl/neosd_dat_fsm.sv
// neosd_dat_fsm: 1-bit DAT0 engine moving one CRC16-protected block per start (read, write, busy wait)
module neosd_dat_fsm #(
  parameter int BLK_BYTES     = 512,
  parameter int TIMEOUT_TICKS = 65535
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   tick_i,
  input  logic                   start_i,
  input  logic [1:0]             mode_i,
  input  logic                   abort_i,
  neosd_dat_fsm_if.master        bus,
  input  logic                   sd_dat0_i,
  output logic                   sd_dat0_o,
  output logic                   sd_dat0_oe,
  output logic                   clk_req_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   crc_err_o,
  output logic                   timeout_o,
  output logic                   overrun_o
);
  localparam int BW = BLK_BYTES > 1 ? $clog2(BLK_BYTES) : 1;
  localparam int TW = TIMEOUT_TICKS > 1 ? $clog2(TIMEOUT_TICKS) : 1;

  typedef enum logic [3:0] {
    IDLE, RD_START, RD_DATA, RD_CRC, RD_END, WR_FETCH, WR_START,
    WR_DATA, WR_CRC, WR_TOKEN, BSY_WAIT, FINISH
  } state_t;

  state_t state, state_n;
  logic [4:0] cnt, cnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [15:0] sh, sh_n, crc, crc_n;
  logic [2:0] tok, tok_n;
  logic [7:0] rd_data_n;
  logic rd_valid_n, done_n, crc_err_n, timeout_n, overrun_n;
  logic last, tmo_hit;

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic d);
    return {c[14:0], 1'b0} ^ ((c[15] ^ d) ? 16'h1021 : 16'h0000);
  endfunction

  assign last    = bcnt == BW'(BLK_BYTES - 1);
  assign tmo_hit = tmo == TW'(TIMEOUT_TICKS - 1);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bcnt_n     = bcnt;
    tmo_n      = tmo;
    sh_n       = sh;
    crc_n      = crc;
    tok_n      = tok;
    rd_data_n  = bus.rd_data;
    rd_valid_n = bus.rd_valid && !bus.rd_ready;
    crc_err_n  = crc_err_o;
    timeout_n  = timeout_o;
    overrun_n  = overrun_o;
    bus.wr_ready = 1'b0;
    case (state)
      IDLE: if (start_i && !abort_i) begin
        crc_err_n = 1'b0;
        timeout_n = 1'b0;
        overrun_n = 1'b0;
        cnt_n     = '0;
        bcnt_n    = '0;
        crc_n     = '0;
        state_n   = mode_i == 2'd1 ? BSY_WAIT : mode_i == 2'd2 ? RD_START :
                    mode_i == 2'd3 ? WR_FETCH : FINISH;
      end
      RD_START: if (tick_i) begin
        if (!sd_dat0_i) begin
          state_n = RD_DATA;
          cnt_n   = '0;
          bcnt_n  = '0;
          crc_n   = '0;
        end else if (tmo_hit) begin
          timeout_n = 1'b1;
          state_n   = FINISH;
        end else tmo_n = tmo + 1'b1;
      end
      RD_DATA: if (tick_i) begin
        sh_n  = {sh[14:0], sd_dat0_i};
        crc_n = crc_upd(crc, sd_dat0_i);
        cnt_n = cnt + 5'd1;
        if (cnt == 5'd7) begin
          cnt_n      = '0;
          rd_data_n  = {sh[6:0], sd_dat0_i};
          rd_valid_n = 1'b1;
          overrun_n  = overrun_o || (bus.rd_valid && !bus.rd_ready);
          bcnt_n     = last ? '0 : bcnt + 1'b1;
          state_n    = last ? RD_CRC : RD_DATA;
        end
      end
      RD_CRC: if (tick_i) begin
        sh_n  = {sh[14:0], sd_dat0_i};
        cnt_n = cnt + 5'd1;
        if (cnt == 5'd15) begin
          crc_err_n = crc_err_o || ({sh[14:0], sd_dat0_i} != crc);
          state_n   = RD_END;
        end
      end
      RD_END: if (tick_i) state_n = FINISH;
      WR_FETCH: if (bus.wr_valid) begin
        bus.wr_ready = 1'b1;
        sh_n    = {8'h00, bus.wr_data};
        cnt_n   = '0;
        state_n = bcnt == '0 ? WR_START : WR_DATA;
      end
      WR_START: if (tick_i) begin
        cnt_n   = cnt == 5'd1 ? 5'd0 : cnt + 5'd1;
        state_n = cnt == 5'd1 ? WR_DATA : WR_START;
      end
      WR_DATA: if (tick_i) begin
        crc_n = crc_upd(crc, sh[7]);
        sh_n  = {sh[14:0], 1'b0};
        cnt_n = cnt + 5'd1;
        if (cnt == 5'd7) begin
          // the next byte is taken on the last tick of bit 7 so a ready source never stalls SDCLK
          cnt_n  = '0;
          bcnt_n = last ? '0 : bcnt + 1'b1;
          if (last) state_n = WR_CRC;
          else if (bus.wr_valid) begin
            bus.wr_ready = 1'b1;
            sh_n = {8'h00, bus.wr_data};
          end else state_n = WR_FETCH;
        end
      end
      WR_CRC: if (tick_i) begin
        crc_n = {crc[14:0], 1'b0};
        cnt_n = cnt == 5'd16 ? 5'd0 : cnt + 5'd1;
        state_n = cnt == 5'd16 ? WR_TOKEN : WR_CRC;
      end
      WR_TOKEN: if (tick_i) begin
        if (cnt == 5'd0) begin
          if (!sd_dat0_i) cnt_n = 5'd1;
          else if (tmo_hit) begin
            timeout_n = 1'b1;
            state_n   = FINISH;
          end else tmo_n = tmo + 1'b1;
        end else begin
          cnt_n = cnt + 5'd1;
          tok_n = {tok[1:0], sd_dat0_i};
          if (cnt == 5'd4) begin
            crc_err_n = crc_err_o || tok != 3'b010;
            state_n   = BSY_WAIT;
          end
        end
      end
      BSY_WAIT: if (tick_i) begin
        if (sd_dat0_i) state_n = FINISH;
        else if (tmo_hit) begin
          timeout_n = 1'b1;
          state_n   = FINISH;
        end else tmo_n = tmo + 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (state_n != state) tmo_n = '0;
    if (abort_i) begin
      state_n      = IDLE;
      rd_valid_n   = 1'b0;
      bus.wr_ready = 1'b0;
    end
    done_n = abort_i || state_n == FINISH;
  end

  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      state        <= IDLE;
      cnt          <= '0;
      bcnt         <= '0;
      tmo          <= '0;
      sh           <= '0;
      crc          <= '0;
      tok          <= '0;
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
      done_o       <= 1'b0;
      crc_err_o    <= 1'b0;
      timeout_o    <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      bcnt         <= bcnt_n;
      tmo          <= tmo_n;
      sh           <= sh_n;
      crc          <= crc_n;
      tok          <= tok_n;
      bus.rd_data  <= rd_data_n;
      bus.rd_valid <= rd_valid_n;
      done_o       <= done_n;
      crc_err_o    <= crc_err_n;
      timeout_o    <= timeout_n;
      overrun_o    <= overrun_n;
    end

  always_comb begin
    busy_o     = state != IDLE;
    clk_req_o  = state != IDLE && state != WR_FETCH;
    sd_dat0_oe = state == WR_START || state == WR_DATA || state == WR_CRC ||
                 (state == WR_FETCH && bcnt != '0);
    sd_dat0_o  = state == WR_START ? cnt == 5'd0 :
                 state == WR_DATA  ? sh[7] :
                 state == WR_CRC   ? (cnt == 5'd16 || crc[15]) : 1'b1;
  end
endmodule
